// File: rtl/serial_rx_align.sv
// Serial-to-parallel receiver: hunts for the comma character bit by bit, confirms a run of
// byte-aligned commas, then delivers each received byte with a valid flag (commas are idle).
module serial_rx_align #(
  parameter logic [7:0]  COMMA      = 8'hBC,
  parameter int unsigned LOCK_COUNT = 4
) (
  input  logic       clk_8f,
  input  logic       reset,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       byte_tick,
  output logic       active
);

  typedef enum logic [1:0] {
    ST_HUNT,
    ST_CONFIRM,
    ST_LOCKED
  } state_t;

  // The comma that brings the count to LOCK_COUNT is the one that locks.
  localparam logic [3:0] LAST_BC = 4'(LOCK_COUNT - 1);

  state_t     state_q;
  logic [6:0] sr_q;
  logic [2:0] cnt_q;
  logic [3:0] bc_cnt_q;
  logic [7:0] data_q;
  logic       valid_q;
  logic       tick_q;
  logic       active_q;

  logic [7:0] window_d;
  logic       is_comma_d;
  logic       boundary_d;

  assign window_d   = {sr_q, data_in};
  assign is_comma_d = (window_d == COMMA);
  assign boundary_d = (cnt_q == 3'd7);

  // NOTE: all state below uses non-blocking assignments so every register samples the
  // pre-edge values of the others, exactly like the flops it describes.
  always_ff @(posedge clk_8f) begin
    if (reset) begin
      state_q  <= ST_HUNT;
      sr_q     <= '0;
      cnt_q    <= '0;
      bc_cnt_q <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      tick_q   <= 1'b0;
      active_q <= 1'b0;
    end else begin
      sr_q   <= window_d[6:0];
      tick_q <= 1'b0;
      case (state_q)
        ST_HUNT: begin
          if (is_comma_d) begin
            state_q  <= ST_CONFIRM;
            cnt_q    <= '0;
            bc_cnt_q <= 4'd1;
          end
        end
        ST_CONFIRM: begin
          cnt_q <= cnt_q + 3'd1;
          if (boundary_d) begin
            if (!is_comma_d) begin
              // Only drop back; the search restarts on the following bit.
              state_q  <= ST_HUNT;
              bc_cnt_q <= '0;
            end else if (bc_cnt_q == LAST_BC) begin
              state_q  <= ST_LOCKED;
              active_q <= 1'b1;
            end else begin
              bc_cnt_q <= bc_cnt_q + 4'd1;
            end
          end
        end
        ST_LOCKED: begin
          cnt_q <= cnt_q + 3'd1;
          if (boundary_d) begin
            data_q  <= window_d;
            valid_q <= !is_comma_d;
            tick_q  <= 1'b1;
          end
        end
        default: state_q <= ST_HUNT;
      endcase
    end
  end

  assign data_out  = data_q;
  assign valid_out = valid_q;
  assign byte_tick = tick_q;
  assign active    = active_q;

endmodule

// File: tb/tb_serial_rx_align.sv
// Scoreboard bench for serial_rx_align: stimulus queues expected bytes and lock edges,
// a negedge monitor pops and compares whenever the receiver presents them.
module tb_serial_rx_align;

  typedef struct {
    int         at_edge;
    logic [7:0] data;
    logic       valid;
  } exp_byte_t;

  logic       clk_8f;
  logic       reset;
  logic       data_in;
  logic [7:0] data_out;
  logic       valid_out;
  logic       byte_tick;
  logic       active;

  int total = 0;
  int bad   = 0;
  int edge_n = 0;
  logic rst_sampled = 1'b0;

  exp_byte_t byte_q[$];
  int        lock_q[$];

  serial_rx_align dut (
    .clk_8f   (clk_8f),
    .reset    (reset),
    .data_in  (data_in),
    .data_out (data_out),
    .valid_out(valid_out),
    .byte_tick(byte_tick),
    .active   (active)
  );

  initial begin
    clk_8f = 1'b0;
    forever #5 clk_8f = ~clk_8f;
  end

  always @(posedge clk_8f) begin
    edge_n      <= edge_n + 1;
    rst_sampled <= reset;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  task automatic flag(input string name);
    total++;
    bad++;
    $display("FAIL %s: got unexpected event expected none (edge %0d)", name, edge_n);
  endtask

  // Monitor: compares outputs half a cycle after each edge.
  initial begin : monitor
    logic       armed;
    logic       prev_active;
    logic [7:0] held_data;
    logic       held_valid;
    exp_byte_t  e;
    int         at;
    armed = 1'b0;
    prev_active = 1'b0;
    held_data = '0;
    held_valid = 1'b0;
    forever begin
      @(negedge clk_8f);
      if (rst_sampled) begin
        armed = 1'b1;
        check("rst_data", 32'(data_out), 32'h00);
        check("rst_valid", 32'(valid_out), 32'h0);
        check("rst_tick", 32'(byte_tick), 32'h0);
        check("rst_active", 32'(active), 32'h0);
        held_data = '0;
        held_valid = 1'b0;
        prev_active = 1'b0;
      end else if (armed) begin
        if (byte_tick === 1'b1) begin
          if (byte_q.size() == 0) begin
            flag("unexpected_byte_tick");
          end else begin
            e = byte_q.pop_front();
            check("byte_edge", 32'(edge_n), 32'(e.at_edge));
            check("byte_data", 32'(data_out), 32'(e.data));
            check("byte_valid", 32'(valid_out), 32'(e.valid));
            held_data = e.data;
            held_valid = e.valid;
          end
        end else begin
          check("tick_low", 32'(byte_tick), 32'h0);
          check("hold_data", 32'(data_out), 32'(held_data));
          check("hold_valid", 32'(valid_out), 32'(held_valid));
        end
        if (active === 1'b1 && !prev_active) begin
          if (lock_q.size() == 0) begin
            flag("unexpected_lock");
          end else begin
            at = lock_q.pop_front();
            check("lock_edge", 32'(edge_n), 32'(at));
          end
        end else if (prev_active) begin
          check("active_stays", 32'(active), 32'h1);
        end
        prev_active = (active === 1'b1);
      end
    end
  end

  task automatic send_bit(input logic b);
    data_in = b;
    @(posedge clk_8f);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      data_in = 1'($urandom_range(0, 1));
      @(posedge clk_8f);
      #1;
    end
    reset = 1'b0;
  endtask

  task automatic expect_byte(input int at, input logic [7:0] d, input logic v);
    exp_byte_t e;
    e.at_edge = at;
    e.data = d;
    e.valid = v;
    byte_q.push_back(e);
  endtask

  task automatic send_commas(input int n);
    for (int i = 0; i < n; i++) send_byte(8'hBC);
  endtask

  initial begin : stimulus
    int base;
    reset = 1'b1;
    data_in = 1'b0;

    // Reset with random serial data.
    do_reset(3);
    check("reset_data_out", 32'(data_out), 32'h00);
    check("reset_active", 32'(active), 32'h0);

    // Aligned lock.
    base = edge_n;
    lock_q.push_back(base + 32);
    expect_byte(base + 40, 8'h5A, 1'b1);
    send_commas(4);
    check("aligned_active", 32'(active), 32'h1);
    send_byte(8'h5A);
    do_reset(1);

    // Misaligned lock after a 3-bit prefix.
    base = edge_n;
    lock_q.push_back(base + 35);
    expect_byte(base + 43, 8'h3C, 1'b1);
    expect_byte(base + 51, 8'hBC, 1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_commas(4);
    send_byte(8'h3C);
    send_byte(8'hBC);
    do_reset(1);

    // Broken confirm: the 0x00 sends it back to hunting.
    base = edge_n;
    lock_q.push_back(base + 56);
    send_commas(2);
    send_byte(8'h00);
    send_commas(3);
    check("broken_not_locked", 32'(active), 32'h0);
    send_commas(1);
    do_reset(1);

    // Data stream after lock.
    base = edge_n;
    lock_q.push_back(base + 32);
    expect_byte(base + 40, 8'h01, 1'b1);
    expect_byte(base + 48, 8'hBC, 1'b0);
    expect_byte(base + 56, 8'hFF, 1'b1);
    expect_byte(base + 64, 8'h80, 1'b1);
    send_commas(4);
    send_byte(8'h01);
    send_byte(8'hBC);
    send_byte(8'hFF);
    send_byte(8'h80);
    do_reset(1);

    // Reset mid-byte while locked, then relock needs a fresh full comma run.
    base = edge_n;
    lock_q.push_back(base + 32);
    expect_byte(base + 40, 8'h77, 1'b1);
    send_commas(4);
    send_byte(8'h77);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    do_reset(1);
    check("midreset_active", 32'(active), 32'h0);
    check("midreset_data", 32'(data_out), 32'h00);
    base = edge_n;
    lock_q.push_back(base + 64);
    expect_byte(base + 72, 8'h42, 1'b1);
    send_commas(3);
    send_byte(8'h11);
    send_commas(4);
    send_byte(8'h42);
    do_reset(1);
    repeat (2) @(posedge clk_8f);
    #1;

    check("bytes_all_seen", 32'(byte_q.size()), 32'h0);
    check("locks_all_seen", 32'(lock_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_rx_align.md
# serial_rx_align

Serial-to-parallel receiver on the `clk_8f` domain of the PHY receive path. It takes the 1-bit serial stream produced by the transmit serializer, finds byte alignment by hunting for the comma character `0xBC`, and locks after a run of aligned commas. Once locked, it delivers each received byte with a `valid_out` flag: comma bytes are idle and carry `valid_out=0`, all other bytes carry `valid_out=1`. Its outputs feed the receive-side byte un-striping logic.

## Interface
- `COMMA`, default `8'hBC`: idle/alignment character.
- `LOCK_COUNT`, default 4: consecutive aligned commas required to lock (range 2..15).
- `clk_8f`  in  1  bit-rate clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `data_in`  in  1  serial data, MSB first, one bit per `clk_8f` cycle.
- `data_out`  out  8  last received byte; held between byte boundaries.
- `valid_out`  out  1  1 if `data_out` is a non-comma byte received while locked; held with `data_out`.
- `byte_tick`  out  1  one-cycle pulse on the cycle `data_out`/`valid_out` update.
- `active`  out  1  high while in LOCKED.

## Operation
- Shift register `sr[6:0]` shifts left each cycle, taking `data_in` as the LSB. Window `w = {sr[6:0], data_in}` is the byte ending on the current bit.
- Phase counter `cnt`: 3 bits, wraps 7→0. Comma counter `bc_cnt`: 4 bits.
- State HUNT:
  - Bitwise search.
  - If `w==COMMA`: go to CONFIRM, `cnt<=0`, `bc_cnt<=1`.
- State CONFIRM:
  - `cnt` increments every cycle.
  - When `cnt==7` (byte boundary), evaluate `w`:
    - `w==COMMA` and `bc_cnt+1==LOCK_COUNT`: go to LOCKED.
    - `w==COMMA` otherwise: `bc_cnt<=bc_cnt+1`.
    - `w!=COMMA`: go to HUNT, `bc_cnt<=0`.
  - The edge that completes a non-comma window only returns to HUNT. It does not restart the search in the same cycle; the search resumes on the next bit.
- State LOCKED:
  - `cnt` keeps counting.
  - At each `cnt==7`: `data_out<=w`, `valid_out<=(w!=COMMA)`, `byte_tick<=1`.
  - `byte_tick` is 0 on all other cycles.
  - LOCKED is left only by reset. No loss-of-lock detection in this block.
- `data_out`, `valid_out` and `byte_tick` update only in LOCKED. In HUNT and CONFIRM they stay 0.
- `active` is a registered output, set on the same edge that enters LOCKED.

## Timing
- Reset (`reset=1` sampled on a rising edge) sets:
  - state HUNT
  - `sr=0`, `cnt=0`, `bc_cnt=0`
  - `data_out=8'h00`, `valid_out=0`, `byte_tick=0`, `active=0`
- Reset mid-operation, including while LOCKED, has the same effect. Alignment must be reacquired from scratch.
- Let edge E be the edge at which the first comma's last bit is sampled.
  - Further aligned commas complete at E+8, E+16, E+24.
  - With `LOCK_COUNT=4`, `active` rises after edge E+24.
  - The first byte after the lock comma completes at E+32. `data_out`/`valid_out`/`byte_tick` are visible after E+32.
  - Every later byte appears 8 cycles after the previous one.
- Latency from a byte's last serial bit to `data_out`: 1 edge (registered on that bit's sampling edge).
- False comma in the data while in HUNT: handled by the CONFIRM check. A non-comma at the next boundary returns to HUNT.
- Comma appearing at a non-boundary bit offset while in CONFIRM or LOCKED: ignored.

## Test plan
- Reset: hold `reset=1` for 3 cycles with random `data_in`.
  - Required: all outputs 0, `active=0`.
- Aligned lock: after reset, send `BC` ×4 starting at bit 0, then `0x5A`.
  - Required: `active=1` after the 32nd bit edge.
  - Required: `data_out=8'h5A`, `valid_out=1` and a one-cycle `byte_tick` after the 40th bit edge.
- Misaligned lock: prefix 3 bits `101`, then `BC` ×4, `0x3C`, `BC`.
  - Required: lock at the 35th bit edge.
  - Required: `0x3C` with `valid_out=1`, then `BC` with `valid_out=0`, 8 cycles apart.
- Broken confirm: send `BC BC 0x00 BC BC BC BC`.
  - Required: return to HUNT after the third byte.
  - Required: `active` rises only after the 7th byte edge (bit 56).
- Data stream: after lock, send `0x01 BC 0xFF 0x80`.
  - Required: `valid_out` sequence 1,0,1,1 with matching `data_out`.
  - Required: `byte_tick` exactly every 8 cycles; outputs held in between.
- Reset while locked: assert `reset` for 1 cycle mid-byte.
  - Required: outputs 0 on the next edge.
  - Required: relock requires a fresh 4-comma run.
